// File: rtl/spw_link_ctrl.sv
// SpaceWire exchange-level link initialisation FSM with transmit credit tracking.
// Optional Run->ErrorReset error counter built only when SPW_LINK_CTRL_ERR_CNT_EN is defined.
module spw_link_ctrl #(
  parameter int Timer6us4Cycles  = 640,
  parameter int Timer12us8Cycles = 1280,
  parameter int CreditMax        = 56
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       link_start_i,
  input  logic       auto_start_i,
  input  logic       link_disable_i,
  input  logic       rx_got_null_i,
  input  logic       rx_got_fct_i,
  input  logic       rx_got_nchar_i,
  input  logic       rx_err_i,
  input  logic       tx_nchar_sent_i,
  output logic [2:0] state_o,
  output logic       rx_enable_o,
  output logic [1:0] tx_mode_o,
  output logic [5:0] tx_credit_o,
  output logic       link_running_o,
  output logic       link_error_o,
  output logic [7:0] err_cnt_o
);

  typedef enum logic [2:0] {
    ST_ERROR_RESET = 3'd0,
    ST_ERROR_WAIT  = 3'd1,
    ST_READY       = 3'd2,
    ST_STARTED     = 3'd3,
    ST_CONNECTING  = 3'd4,
    ST_RUN         = 3'd5
  } state_t;

  localparam int TimerMax = (Timer6us4Cycles > Timer12us8Cycles) ? Timer6us4Cycles : Timer12us8Cycles;
  localparam int TimerW   = $clog2(TimerMax + 1);
  localparam logic [TimerW-1:0] ErTimeout = TimerW'(Timer6us4Cycles - 1);
  localparam logic [TimerW-1:0] TwTimeout = TimerW'(Timer12us8Cycles - 1);
  localparam logic [6:0]        CreditLim = 7'(CreditMax);

  state_t              state_r;
  state_t              state_next_s;
  logic [TimerW-1:0]   timer_r;
  logic                got_null_r;
  logic [5:0]          credit_r;
  logic [5:0]          credit_next_s;
  logic [6:0]          credit_sum_s;
  logic                credit_dec_s;
  logic                credit_err_s;
  logic                in_conn_run_s;
  logic                err_s;
  logic                rx_enable_r;
  logic [1:0]          tx_mode_r;
  logic [1:0]          tx_mode_next_s;
  logic                link_running_r;
  logic                link_error_r;

  assign err_s         = rx_err_i | link_disable_i;
  assign in_conn_run_s = (state_r == ST_CONNECTING) || (state_r == ST_RUN);

  // Credit arithmetic; a send at zero credit never borrows.
  always_comb begin
    credit_dec_s = tx_nchar_sent_i && (credit_r != 6'd0);
    credit_sum_s = {1'b0, credit_r} + (rx_got_fct_i ? 7'd8 : 7'd0) - {6'd0, credit_dec_s};
    credit_err_s = in_conn_run_s && rx_got_fct_i && (credit_sum_s > CreditLim);
  end

  // Next-state selection, highest-priority condition first in each state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_ERROR_RESET: begin
        if (timer_r == ErTimeout) state_next_s = ST_ERROR_WAIT;
        else                      state_next_s = ST_ERROR_RESET;
      end
      ST_ERROR_WAIT: begin
        if (err_s || rx_got_fct_i || rx_got_nchar_i) state_next_s = ST_ERROR_RESET;
        else if (timer_r == TwTimeout)               state_next_s = ST_READY;
        else                                         state_next_s = ST_ERROR_WAIT;
      end
      ST_READY: begin
        if (err_s || rx_got_fct_i || rx_got_nchar_i)        state_next_s = ST_ERROR_RESET;
        else if (link_start_i || (auto_start_i && got_null_r)) state_next_s = ST_STARTED;
        else                                                state_next_s = ST_READY;
      end
      ST_STARTED: begin
        if (err_s || rx_got_fct_i || rx_got_nchar_i) state_next_s = ST_ERROR_RESET;
        else if (got_null_r || rx_got_null_i)        state_next_s = ST_CONNECTING;
        else if (timer_r == TwTimeout)               state_next_s = ST_ERROR_RESET;
        else                                         state_next_s = ST_STARTED;
      end
      ST_CONNECTING: begin
        if (err_s || rx_got_nchar_i || credit_err_s) state_next_s = ST_ERROR_RESET;
        else if (rx_got_fct_i)                       state_next_s = ST_RUN;
        else if (timer_r == TwTimeout)               state_next_s = ST_ERROR_RESET;
        else                                         state_next_s = ST_CONNECTING;
      end
      ST_RUN: begin
        if (err_s || credit_err_s) state_next_s = ST_ERROR_RESET;
        else                       state_next_s = ST_RUN;
      end
      default: state_next_s = ST_ERROR_RESET;
    endcase
  end

  // Output and credit values for the state being entered, so they register alongside it.
  always_comb begin
    tx_mode_next_s = 2'd0;
    case (state_next_s)
      ST_STARTED:    tx_mode_next_s = 2'd1;
      ST_CONNECTING: tx_mode_next_s = 2'd2;
      ST_RUN:        tx_mode_next_s = 2'd3;
      default:       tx_mode_next_s = 2'd0;
    endcase
    credit_next_s = 6'd0;
    if ((state_next_s == ST_CONNECTING) || (state_next_s == ST_RUN)) begin
      if (in_conn_run_s && !credit_err_s) credit_next_s = credit_sum_s[5:0];
      else                                credit_next_s = credit_r;
    end else begin
      credit_next_s = 6'd0;
    end
  end

  // State, timer, NULL latch, credit and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_ERROR_RESET;
      timer_r        <= '0;
      got_null_r     <= 1'b0;
      credit_r       <= 6'd0;
      rx_enable_r    <= 1'b0;
      tx_mode_r      <= 2'd0;
      link_running_r <= 1'b0;
      link_error_r   <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      timer_r        <= (state_next_s != state_r) ? '0 : timer_r + TimerW'(1);
      got_null_r     <= (state_r == ST_ERROR_RESET) ? 1'b0 : (got_null_r | (rx_enable_r & rx_got_null_i));
      credit_r       <= credit_next_s;
      rx_enable_r    <= (state_next_s != ST_ERROR_RESET);
      tx_mode_r      <= tx_mode_next_s;
      link_running_r <= (state_next_s == ST_RUN);
      link_error_r   <= (state_next_s == ST_ERROR_RESET) && (state_r != ST_ERROR_RESET);
    end
  end

`ifdef SPW_LINK_CTRL_ERR_CNT_EN
  logic [7:0] err_cnt_r;

  // Saturating count of link drops out of Run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 8'd0;
    end else if ((state_r == ST_RUN) && (state_next_s == ST_ERROR_RESET) && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt_o = err_cnt_r;
`else
  assign err_cnt_o = 8'd0;
`endif

  assign state_o        = state_r;
  assign rx_enable_o    = rx_enable_r;
  assign tx_mode_o      = tx_mode_r;
  assign tx_credit_o    = credit_r;
  assign link_running_o = link_running_r;
  assign link_error_o   = link_error_r;

endmodule

// File: tb/tb_spw_link_ctrl.sv
// Randomised and directed bench for spw_link_ctrl against a cycle-level reference model.
module tb_spw_link_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, link_start, auto_start, link_disable;
  logic       rx_null, rx_fct, rx_nchar, rx_err, tx_sent;
  logic [2:0] state;
  logic       rx_enable;
  logic [1:0] tx_mode;
  logic [5:0] tx_credit;
  logic       running, link_error;
  logic [7:0] err_cnt;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state (plain integers)
  int m_state, m_timer, m_credit, m_errcnt, m_lerr, m_got_null;

`ifdef SPW_LINK_CTRL_ERR_CNT_EN
  localparam int CntOn = 1;
`else
  localparam int CntOn = 0;
`endif

  spw_link_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .link_start_i(link_start), .auto_start_i(auto_start), .link_disable_i(link_disable),
    .rx_got_null_i(rx_null), .rx_got_fct_i(rx_fct), .rx_got_nchar_i(rx_nchar),
    .rx_err_i(rx_err), .tx_nchar_sent_i(tx_sent),
    .state_o(state), .rx_enable_o(rx_enable), .tx_mode_o(tx_mode), .tx_credit_o(tx_credit),
    .link_running_o(running), .link_error_o(link_error), .err_cnt_o(err_cnt)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_timer = 0; m_credit = 0; m_errcnt = 0; m_lerr = 0; m_got_null = 0;
  endtask

  task automatic model_step();
    int  nxt, dec, sum;
    bit  err, cerr, bad_rx;
    err    = rx_err || link_disable;
    bad_rx = err || rx_fct || rx_nchar;
    dec    = (tx_sent && m_credit > 0) ? 1 : 0;
    sum    = m_credit + (rx_fct ? 8 : 0) - dec;
    cerr   = rx_fct && (sum > 56) && (m_state >= 4);
    nxt    = m_state;
    case (m_state)
      0: if (m_timer == 639) nxt = 1;
      1: if (bad_rx) nxt = 0; else if (m_timer == 1279) nxt = 2;
      2: if (bad_rx) nxt = 0; else if (link_start || (auto_start && m_got_null != 0)) nxt = 3;
      3: if (bad_rx) nxt = 0; else if (m_got_null != 0 || rx_null) nxt = 4; else if (m_timer == 1279) nxt = 0;
      4: if (err || rx_nchar || cerr) nxt = 0; else if (rx_fct) nxt = 5; else if (m_timer == 1279) nxt = 0;
      5: if (err || cerr) nxt = 0;
      default: nxt = 0;
    endcase
    m_credit   = (nxt >= 4 && m_state >= 4) ? sum : 0;
    if (CntOn != 0 && m_state == 5 && nxt == 0 && m_errcnt < 255) m_errcnt++;
    m_lerr     = (nxt == 0 && m_state != 0) ? 1 : 0;
    m_got_null = (m_state == 0) ? 0 : ((m_got_null != 0 || rx_null) ? 1 : 0);
    m_timer    = (nxt != m_state) ? 0 : m_timer + 1;
    m_state    = nxt;
  endtask

  task automatic cmp_all();
    check_eq("state", int'(state), m_state);
    check_eq("rx_enable", int'(rx_enable), (m_state != 0) ? 1 : 0);
    check_eq("tx_mode", int'(tx_mode), (m_state >= 3) ? m_state - 2 : 0);
    check_eq("credit", int'(tx_credit), m_credit);
    check_eq("running", int'(running), (m_state == 5) ? 1 : 0);
    check_eq("link_error", int'(link_error), m_lerr);
    check_eq("err_cnt", int'(err_cnt), m_errcnt);
  endtask

  task automatic cycle(input bit nul, input bit fct, input bit nch, input bit er, input bit snt);
    rx_null = nul; rx_fct = fct; rx_nchar = nch; rx_err = er; tx_sent = snt;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_all();
    rx_null = 1'b0; rx_fct = 1'b0; rx_nchar = 1'b0; rx_err = 1'b0; tx_sent = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_state"}, int'(state), 0);
    check_eq({tag, "_rx_en"}, int'(rx_enable), 0);
    check_eq({tag, "_tx_mode"}, int'(tx_mode), 0);
    check_eq({tag, "_credit"}, int'(tx_credit), 0);
    check_eq({tag, "_running"}, int'(running), 0);
    check_eq({tag, "_lerr"}, int'(link_error), 0);
    check_eq({tag, "_errcnt"}, int'(err_cnt), 0);
  endtask

  // Ready -> Started -> Connecting -> Run via explicit start, NULL and FCT.
  task automatic bring_up();
    link_start = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    link_start = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; link_start = 1'b0; auto_start = 1'b0; link_disable = 1'b0;
    rx_null = 1'b0; rx_fct = 1'b0; rx_nchar = 1'b0; rx_err = 1'b0; tx_sent = 1'b0;
    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // power-up dwell times
    idle(639);
    check_eq("er_dwell_end", int'(state), 0);
    idle(1);
    check_eq("er_to_ew", int'(state), 1);
    check_eq("rx_en_after_er", int'(rx_enable), 1);
    idle(1280);
    check_eq("ew_to_ready", int'(state), 2);

    auto_start = 1'b1;
    idle(10);
    check_eq("auto_no_null", int'(state), 2);
    auto_start = 1'b0;

    // start sequence
    link_start = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    link_start = 1'b0;
    check_eq("started", int'(state), 3);
    check_eq("started_mode", int'(tx_mode), 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("connecting", int'(state), 4);
    check_eq("connecting_mode", int'(tx_mode), 2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("run", int'(state), 5);
    check_eq("run_mode", int'(tx_mode), 3);
    check_eq("run_credit", int'(tx_credit), 8);

    // credit boundaries
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("credit_48", int'(tx_credit), 48);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("credit_net7", int'(tx_credit), 55);
    check_eq("credit_net7_run", int'(state), 5);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("credit_49", int'(tx_credit), 49);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("credit_err_state", int'(state), 0);
    check_eq("credit_err_lerr", int'(link_error), 1);
    check_eq("credit_err_clear", int'(tx_credit), 0);

    // FCT during ErrorWait aborts it
    idle(640);
    check_eq("ew_again", int'(state), 1);
    idle(5);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("ew_fct_abort", int'(state), 0);
    idle(1920);
    check_eq("ready_again", int'(state), 2);

    // Started timeout
    link_start = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    link_start = 1'b0;
    idle(1279);
    check_eq("started_hold", int'(state), 3);
    idle(1);
    check_eq("started_timeout", int'(state), 0);
    check_eq("timeout_lerr", int'(link_error), 1);
    idle(1);
    check_eq("lerr_one_cycle", int'(link_error), 0);
    idle(1919);
    check_eq("ready_after_to", int'(state), 2);

    // forced drops out of Run via link_disable
    for (int k = 0; k < 3; k++) begin
      bring_up();
      link_disable = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      link_disable = 1'b0;
      check_eq("disable_drop", int'(state), 0);
      idle(1920);
    end
    check_eq("err_cnt_total", int'(err_cnt), (CntOn != 0) ? 4 : 0);

    // randomised traffic
    for (int i = 0; i < 20000; i++) begin
      link_start   = ($urandom_range(0, 3) == 0);
      auto_start   = ($urandom_range(0, 1) == 0);
      link_disable = ($urandom_range(0, 2047) == 0);
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
            $urandom_range(0, 1023) == 0, $urandom_range(0, 3) == 0);
    end
    link_start = 1'b0; auto_start = 1'b0; link_disable = 1'b0;

    // asynchronous reset mid-operation
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
